// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron readout path.
// Holds the membrane bus width, detector state encoding and saturating increment.
package snn_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    ARMED = 1'b0,
    FIRED = 1'b1
  } det_state_t;

  // Increment that sticks at 2^width-1; callers zero-extend into and truncate out of 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    if (width >= 32) begin
      max_val = '1;
    end else begin
      max_val = (32'd1 << width) - 32'd1;
    end
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/spike_detector.sv
// Threshold crossing detector with hysteresis re-arm on the membrane potential.
// detect is this cycle's crossing; spike_o is the same event one cycle later.
module spike_detector
  import snn_pkg::*;
#(
  parameter logic [DATA_W-1:0] THRESH = 8'd200,
  parameter logic [DATA_W-1:0] HYST   = 8'd32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] v_mem,
  output logic              detect,
  output logic              spike_o,
  output det_state_t        state_o
);

  localparam logic [DATA_W-1:0] REARM = THRESH - HYST;

  det_state_t state, state_next;

  always_comb begin
    state_next = state;
    detect     = 1'b0;
    if (en) begin
      case (state)
        ARMED: begin
          if (v_mem >= THRESH) begin
            state_next = FIRED;
            detect     = 1'b1;
          end
        end
        FIRED: begin
          if (v_mem < REARM) begin
            state_next = ARMED;
          end
        end
        default: state_next = ARMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARMED;
      spike_o <= 1'b0;
    end else begin
      state   <= state_next;
      spike_o <= detect;
    end
  end

  assign state_o = state;

endmodule

// File: rtl/spike_rate_monitor.sv
// Spike detection, windowed firing-rate count and inter-spike interval measurement
// for the QIF neuron membrane potential.
module spike_rate_monitor
  import snn_pkg::*;
#(
  parameter logic [DATA_W-1:0] THRESH = 8'd200,
  parameter logic [DATA_W-1:0] HYST   = 8'd32,
  parameter logic [23:0]       WINDOW = 24'd10_000_000,
  parameter int                CNT_W  = 8,
  parameter int                ISI_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] v_mem,
  output logic              spike_o,
  output logic [CNT_W-1:0]  rate_o,
  output logic              rate_valid_o,
  output logic [ISI_W-1:0]  isi_o,
  output logic              isi_valid_o
);

  localparam int WIN_W = (WINDOW > 24'd2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 24'd1);

  if (HYST > THRESH) begin : g_bad_hyst
    $error("spike_rate_monitor: HYST must not exceed THRESH");
  end
  if (WINDOW < 24'd2) begin : g_bad_window
    $error("spike_rate_monitor: WINDOW must be at least 2");
  end

  logic             detect;
  det_state_t       det_state;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] spike_cnt;
  logic [CNT_W-1:0] spike_cnt_inc;
  logic [ISI_W-1:0] isi_cnt;
  logic [ISI_W-1:0] isi_cnt_inc;
  logic             have_prev;
  logic             win_end;

  spike_detector #(
    .THRESH (THRESH),
    .HYST   (HYST)
  ) u_detector (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .v_mem   (v_mem),
    .detect  (detect),
    .spike_o (spike_o),
    .state_o (det_state)
  );

  assign win_end       = en && (win_cnt == WIN_LAST);
  assign spike_cnt_inc = CNT_W'(sat_inc(32'(spike_cnt), CNT_W));
  assign isi_cnt_inc   = ISI_W'(sat_inc(32'(isi_cnt), ISI_W));

  // All three *_o pulses are single-cycle strobes with no backpressure: the value
  // bus (rate_o / isi_o) is stable from the strobe cycle until the next strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt      <= '0;
      spike_cnt    <= '0;
      isi_cnt      <= '0;
      have_prev    <= 1'b0;
      rate_o       <= '0;
      rate_valid_o <= 1'b0;
      isi_o        <= '0;
      isi_valid_o  <= 1'b0;
    end else begin
      rate_valid_o <= win_end;
      isi_valid_o  <= detect && have_prev;
      if (en) begin
        win_cnt <= win_end ? '0 : win_cnt + WIN_W'(1);
        // A detection on the closing cycle still belongs to the closing window.
        if (win_end) begin
          rate_o    <= detect ? spike_cnt_inc : spike_cnt;
          spike_cnt <= '0;
        end else if (detect) begin
          spike_cnt <= spike_cnt_inc;
        end
        if (detect) begin
          isi_cnt   <= '0;
          have_prev <= 1'b1;
          if (have_prev) begin
            isi_o <= isi_cnt_inc;
          end
        end else begin
          isi_cnt <= isi_cnt_inc;
        end
      end
    end
  end

  a_spike_single : assert property (@(posedge clk) disable iff (!rst_n) spike_o |=> !spike_o);
  a_spike_fired  : assert property (@(posedge clk) disable iff (!rst_n) spike_o |-> det_state == FIRED);

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Scoreboard bench for spike_rate_monitor: directed membrane traces with hand-computed
// spike cycles, ISI values and window rates; a second instance covers saturation.
module tb_spike_rate_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  v_mem;
  logic        spike_o;
  logic [7:0]  rate_o;
  logic        rate_valid_o;
  logic [15:0] isi_o;
  logic        isi_valid_o;

  logic        rst2_n;
  logic [7:0]  v_mem2;
  logic        spike2;
  logic [3:0]  rate2;
  logic        rate_valid2;
  logic [15:0] isi2;
  logic        isi_valid2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rate2_pulses = 0;
  logic done2 = 1'b0;
  logic prev_spike = 1'b0;

  logic [31:0] exp_spike_q[$];
  logic [31:0] exp_rate_q[$];
  logic [31:0] exp_rate_cyc_q[$];
  logic [31:0] exp_isi_q[$];
  logic [31:0] exp_isi2_q[$];

  spike_rate_monitor #(
    .THRESH (8'd200), .HYST (8'd32), .WINDOW (24'd100), .CNT_W (8), .ISI_W (16)
  ) dut (
    .clk (clk), .rst_n (rst_n), .en (en), .v_mem (v_mem), .spike_o (spike_o),
    .rate_o (rate_o), .rate_valid_o (rate_valid_o), .isi_o (isi_o), .isi_valid_o (isi_valid_o)
  );

  spike_rate_monitor #(
    .THRESH (8'd200), .HYST (8'd32), .WINDOW (24'd100), .CNT_W (4), .ISI_W (16)
  ) dut_sat (
    .clk (clk), .rst_n (rst2_n), .en (1'b1), .v_mem (v_mem2), .spike_o (spike2),
    .rate_o (rate2), .rate_valid_o (rate_valid2), .isi_o (isi2), .isi_valid_o (isi_valid2)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: pulse with no expected entry (cycle %0d)", name, cyc);
  endtask

  // ---------------- stimulus tables ----------------
  function automatic logic [7:0] v_at(input int r);
    if (r >= 10 && r <= 29) return 8'd210;
    if (r >= 30 && r <= 34) return 8'd180;
    if (r >= 35 && r <= 39) return 8'd210;
    if (r >= 40 && r <= 44) return 8'd160;
    if (r >= 45 && r <= 49) return 8'd210;
    if (r >= 220 && r <= 249) return 8'd210;
    case (r)
      95, 110, 120, 130, 140, 150, 160, 200, 210, 260, 440, 533: return 8'd210;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic en_at(input int r);
    return !(r >= 220 && r <= 249);
  endfunction

  // ---------------- driver: main instance ----------------
  initial begin
    int base;
    int sp[13] = '{10, 45, 95, 110, 120, 130, 140, 150, 160, 200, 210, 260, 440};
    int iv[12] = '{35, 50, 15, 10, 10, 10, 10, 10, 40, 10, 20, 180};
    int rv[5]  = '{3, 7, 2, 0, 1};
    int rc[5]  = '{100, 200, 330, 430, 530};
    rst_n = 1'b0;
    en    = 1'b1;
    v_mem = 8'd0;
    #1;
    check("reset_spike", 32'(spike_o), 0);
    check("reset_rate", 32'(rate_o), 0);
    check("reset_isi", 32'(isi_o), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    base = cyc;
    foreach (sp[i]) exp_spike_q.push_back(32'(base + sp[i]));
    foreach (iv[i]) exp_isi_q.push_back(32'(iv[i]));
    foreach (rv[i]) begin
      exp_rate_q.push_back(32'(rv[i]));
      exp_rate_cyc_q.push_back(32'(base + rc[i]));
    end
    for (int r = 1; r <= 533; r++) begin
      v_mem = v_at(r);
      en    = en_at(r);
      @(posedge clk);
      #1;
    end
    check("pre_reset_spike", 32'(spike_o), 1);
    check("pre_reset_isi_valid", 32'(isi_valid_o), 1);
    check("pre_reset_isi", 32'(isi_o), 93);
    check("pre_reset_rate", 32'(rate_o), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_spike", 32'(spike_o), 0);
    check("async_reset_rate", 32'(rate_o), 0);
    check("async_reset_rate_valid", 32'(rate_valid_o), 0);
    check("async_reset_isi", 32'(isi_o), 0);
    check("async_reset_isi_valid", 32'(isi_valid_o), 0);
    v_mem = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    base = cyc;
    exp_spike_q.push_back(32'(base + 5));
    exp_spike_q.push_back(32'(base + 17));
    exp_isi_q.push_back(32'd12);
    for (int r = 1; r <= 30; r++) begin
      v_mem = (r == 5 || r == 17) ? 8'd210 : 8'd0;
      @(posedge clk);
      #1;
    end
    en = 1'b0;
    for (int i = 0; i < 80000 && !done2; i++) @(posedge clk);
    check("sat_run_done", 32'(done2), 1);
    repeat (3) @(posedge clk);
    check("rate2_pulse_count", 32'(rate2_pulses), 700);
    check("spike_q_empty", 32'(exp_spike_q.size()), 0);
    check("rate_q_empty", 32'(exp_rate_q.size()), 0);
    check("isi_q_empty", 32'(exp_isi_q.size()), 0);
    check("isi2_q_empty", 32'(exp_isi2_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- driver: saturation instance ----------------
  initial begin
    rst2_n = 1'b0;
    v_mem2 = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst2_n = 1'b1;
    for (int i = 0; i < 19; i++) exp_isi2_q.push_back(32'd2);
    exp_isi2_q.push_back(32'd65535);
    for (int r = 1; r <= 70040; r++) begin
      v_mem2 = ((r <= 40 && (r % 2) == 1) || r == 70039) ? 8'd210 : 8'd0;
      @(posedge clk);
      #1;
    end
    done2 = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (spike_o) begin
      check("spike_back_to_back", 32'(prev_spike), 0);
      if (exp_spike_q.size() == 0) unexpected("spike");
      else check("spike_cycle", 32'(cyc), exp_spike_q.pop_front());
    end
    prev_spike = spike_o;
    if (rate_valid_o) begin
      if (exp_rate_q.size() == 0) unexpected("rate_valid");
      else begin
        check("rate_value", 32'(rate_o), exp_rate_q.pop_front());
        check("rate_cycle", 32'(cyc), exp_rate_cyc_q.pop_front());
      end
    end
    if (isi_valid_o) begin
      check("isi_with_spike", 32'(spike_o), 1);
      if (exp_isi_q.size() == 0) unexpected("isi_valid");
      else check("isi_value", 32'(isi_o), exp_isi_q.pop_front());
    end
    if (rate_valid2) begin
      check("sat_rate_value", 32'(rate2), (rate2_pulses == 0) ? 32'd15 : 32'd0);
      rate2_pulses++;
    end
    if (isi_valid2) begin
      if (exp_isi2_q.size() == 0) unexpected("sat_isi_valid");
      else check("sat_isi_value", 32'(isi2), exp_isi2_q.pop_front());
    end
  end

endmodule
